op12_arbiter: RTL and testbench
===============================

Name: op12_arbiter

Overview:
- Shares one combinational 12-bit datapath between two requesters. The datapath takes operands A and B and produces three 12-bit results C, D and E.
- Each requester presents an operand pair plus a result selector over a valid/ready handshake.
- The block arbitrates round-robin, drives the shared datapath, waits a fixed settle time, then captures the selected result.
- It returns the result on a single response channel tagged with the requester ID.

Parameters:
- WIDTH, 12, operand/result width.
- SETTLE_CYCLES, 1, cycles operands are held on dp_a/dp_b before capture; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  2  requester 0 selector: 0=C, 1=D, 2=E, 3=illegal.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- dp_a  output  WIDTH  operand A to shared datapath (registered).
- dp_b  output  WIDTH  operand B to shared datapath (registered).
- dp_c  input  WIDTH  datapath result C.
- dp_d  input  WIDTH  datapath result D.
- dp_e  input  WIDTH  datapath result E.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  captured result.
- rsp_id  output  1  requester that issued the request.
- rsp_err  output  1  op was 3; rsp_data forced to 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock (clk). rst is synchronous, active-high, and overrides everything, including mid-operation; any in-flight request is dropped with no response.
- Reset values: state=IDLE; dp_a=dp_b=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; last_grant=1, so requester 0 wins the first contention; settle counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, for the granted requester.
  - Grant if only one valid: that one.
  - Grant if both valid: the one != last_grant.
  - Grant if none valid: stay in IDLE, both ready=0.
  - On handshake (valid & ready): latch a→dp_a, b→dp_b, op and id internally; last_grant←id; counter←SETTLE_CYCLES; go to WAIT.
- WAIT:
  - Counter decrements each edge; both readies are 0; dp_a/dp_b stable.
  - At the edge where counter==1: capture rsp_data per op (0→dp_c, 1→dp_d, 2→dp_e, 3→0 with rsp_err=1, otherwise rsp_err=0); rsp_id←latched id; rsp_valid←1; go to RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On that edge: rsp_valid←0, go to IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the cycle after.
- Latency: accept edge k → rsp_valid high after edge k+SETTLE_CYCLES.
- Throughput: one operation per SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- Hold values: dp_a/dp_b keep their last operands after completion. rsp_data/rsp_id/rsp_err keep their last value when rsp_valid=0.
- No combinational path from dp_c/d/e to any output.
- Starvation: under continuous contention, grants strictly alternate.
- Requests with valid deasserted before ready are simply not taken; requesters must hold valid until ready, but the block does not check this.

Test Plan:
- Bench datapath stub: dp_c=dp_a&dp_b, dp_d=dp_a|dp_b, dp_e=dp_a^dp_b.
- Reset, then req0 alone with a=12'ha4b, b=12'h101, op=0, SETTLE_CYCLES=1, rsp_ready=1 → req0_ready high in first IDLE cycle; dp_a=a4b/dp_b=101 next cycle; rsp_valid one cycle after accept with rsp_data=12'h001, rsp_id=0, rsp_err=0.
- Same operands with op=1 then op=2 on req1 → rsp_data=12'hb4b then 12'hb4a, rsp_id=1, each 3 cycles apart.
- Both valid continuously after reset, four ops each → grant order 0,1,0,1,…; rsp_id alternates; no requester waits more than one operation.
- op=3 from req0 → rsp_valid with rsp_data=0, rsp_err=1; next legal op clears rsp_err to 0.
- rsp_ready held low 5 cycles in RESP with req1_valid high → rsp_valid/data/id stable; req1_ready stays 0; req1 accepted the cycle after the rsp_ready=1 edge.
- rst asserted during WAIT with SETTLE_CYCLES=4 → next cycle state IDLE, dp_a=dp_b=0, rsp_valid=0; the dropped request never responds; first post-reset contention grants req0.

Source files
------------

// File: rtl/op12_arbiter.sv
// op12_arbiter: round-robin sharing of one combinational 12-bit datapath
// between two requesters.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op     requester N handshake, operands and result selector
//                               (reqN_ready is combinational: IDLE and granted)
//   dp_a, dp_b                  registered operands to the shared datapath
//   dp_c, dp_d, dp_e            datapath results (sampled only into registers)
//   rsp_valid/ready/data/id/err response channel, tagged with requester id
//   busy                        high whenever the block is not idle
module op12_arbiter #(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_c,
  input  logic [WIDTH-1:0] dp_d,
  input  logic [WIDTH-1:0] dp_e,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dp_a_q, dp_a_d;
  logic [WIDTH-1:0]   dp_b_q, dp_b_d;
  logic [1:0]         op_q, op_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               gnt0, gnt1;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          id_d         = gnt1;
          last_grant_d = gnt1;
          dp_a_d       = gnt1 ? req1_a  : req0_a;
          dp_b_d       = gnt1 ? req1_b  : req0_b;
          op_d         = gnt1 ? req1_op : req0_op;
          cnt_d        = CNT_W'(SETTLE_CYCLES);
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last settle cycle: datapath outputs are stable, capture the result.
        if (cnt_q == CNT_W'(1)) begin
          rsp_err_d = 1'b0;
          unique case (op_q)
            2'd0:    rsp_data_d = dp_c;
            2'd1:    rsp_data_d = dp_d;
            2'd2:    rsp_data_d = dp_e;
            default: begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end
          endcase
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      op_q         <= 2'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_op12_arbiter.sv
// Testbench for op12_arbiter: instance A (settle 1) carries the table,
// hand-written sequences and randomized checks; instance B (settle 4) shares
// the inputs and covers latency and reset during WAIT.
module tb_op12_arbiter;

  localparam int unsigned W   = 12;
  localparam int unsigned S_A = 1;
  localparam int unsigned S_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;

  logic         a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id, a_rsp_err, a_busy;
  logic [W-1:0] a_dp_a, a_dp_b, a_dp_c, a_dp_d, a_dp_e, a_rsp_data;
  logic         b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_err, b_busy;
  logic [W-1:0] b_dp_a, b_dp_b, b_dp_c, b_dp_d, b_dp_e, b_rsp_data;

  // Datapath stubs
  assign a_dp_c = a_dp_a & a_dp_b;
  assign a_dp_d = a_dp_a | a_dp_b;
  assign a_dp_e = a_dp_a ^ a_dp_b;
  assign b_dp_c = b_dp_a & b_dp_b;
  assign b_dp_d = b_dp_a | b_dp_b;
  assign b_dp_e = b_dp_a ^ b_dp_b;

  op12_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .dp_a(a_dp_a), .dp_b(a_dp_b), .dp_c(a_dp_c), .dp_d(a_dp_d), .dp_e(a_dp_e),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_id(a_rsp_id),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  op12_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .dp_a(b_dp_a), .dp_b(b_dp_b), .dp_c(b_dp_c), .dp_d(b_dp_d), .dp_e(b_dp_e),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_id(b_rsp_id),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] op);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic rst_pulse();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'd0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'd0;
    rsp_ready  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Expected result from the operation definition: C=a&b, D=a|b, E=a^b, 3 -> 0.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int got;
    int seen;
    logic [W-1:0] held_data;
    bit           m_busy;
    int           m_acc;
    logic         m_id, m_last;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_op;
    logic         hs0, hs1, g0, g1, exp_rv;

    vecs[0] = '{1'b0, 12'ha4b, 12'h101, 2'd0, 12'h001, 1'b0};
    vecs[1] = '{1'b1, 12'ha4b, 12'h101, 2'd1, 12'hb4b, 1'b0};
    vecs[2] = '{1'b1, 12'ha4b, 12'h101, 2'd2, 12'hb4a, 1'b0};
    vecs[3] = '{1'b0, 12'hfff, 12'hfff, 2'd3, 12'h000, 1'b1};
    vecs[4] = '{1'b0, 12'hf0f, 12'h0ff, 2'd0, 12'h00f, 1'b0};
    vecs[5] = '{1'b1, 12'h000, 12'h000, 2'd1, 12'h000, 1'b0};
    vecs[6] = '{1'b0, 12'hfff, 12'h000, 2'd2, 12'hfff, 1'b0};
    vecs[7] = '{1'b1, 12'h800, 12'h001, 2'd3, 12'h000, 1'b1};

    // Reset values
    rst = 1'b1;
    rst_pulse();
    chk("reset_busy",      32'(a_busy),      32'(0));
    chk("reset_rsp_valid", 32'(a_rsp_valid), 32'(0));
    chk("reset_rsp_data",  32'(a_rsp_data),  32'(0));
    chk("reset_rsp_id",    32'(a_rsp_id),    32'(0));
    chk("reset_rsp_err",   32'(a_rsp_err),   32'(0));
    chk("reset_dp_a",      32'(a_dp_a),      32'(0));
    chk("reset_dp_b",      32'(a_dp_b),      32'(0));

    // Table-driven single transactions, back to back every 3 cycles
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk($sformatf("v%0d_ready_granted", i), 32'(vecs[i].id ? a_req1_ready : a_req0_ready), 32'(1));
      chk($sformatf("v%0d_ready_other", i),   32'(vecs[i].id ? a_req0_ready : a_req1_ready), 32'(0));
      step();
      set_req(vecs[i].id, 1'b0, vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("v%0d_busy", i),       32'(a_busy),      32'(1));
      chk($sformatf("v%0d_dp_a", i),       32'(a_dp_a),      32'(vecs[i].a));
      chk($sformatf("v%0d_dp_b", i),       32'(a_dp_b),      32'(vecs[i].b));
      chk($sformatf("v%0d_rsp_early", i),  32'(a_rsp_valid), 32'(0));
      step();
      chk($sformatf("v%0d_rsp_valid", i),  32'(a_rsp_valid), 32'(1));
      chk($sformatf("v%0d_rsp_data", i),   32'(a_rsp_data),  32'(vecs[i].exp_data));
      chk($sformatf("v%0d_rsp_id", i),     32'(a_rsp_id),    32'(vecs[i].id));
      chk($sformatf("v%0d_rsp_err", i),    32'(a_rsp_err),   32'(vecs[i].exp_err));
      step();
      chk($sformatf("v%0d_rsp_done", i),   32'(a_rsp_valid), 32'(0));
      chk($sformatf("v%0d_idle", i),       32'(a_busy),      32'(0));
    end

    // Continuous contention: grants alternate starting with requester 0
    rst_pulse();
    set_req(1'b0, 1'b1, 12'h0f0, 12'h0ff, 2'd0);
    set_req(1'b1, 1'b1, 12'h0f0, 12'h00f, 2'd1);
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      step();
      if (a_rsp_valid) begin
        chk($sformatf("rr_id_%0d", got),   32'(a_rsp_id),   32'(got % 2));
        chk($sformatf("rr_data_%0d", got), 32'(a_rsp_data), (got % 2 == 0) ? 32'h0f0 : 32'h0ff);
        got++;
        if (got == 8) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    chk("rr_count", 32'(got), 32'(8));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Back-pressure: response held while rsp_ready low, req1 waits
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 12'h123, 12'h0f0, 2'd1);
    step();
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 12'h555, 12'h0ff, 2'd0);
    step();
    held_data = a_rsp_data;
    chk("bp_data", 32'(a_rsp_data), 32'h1f3);
    chk("bp_id",   32'(a_rsp_id),   32'(0));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), 32'(a_rsp_valid),  32'(1));
      chk($sformatf("bp_hold_%0d", i),  32'(a_rsp_data),   32'(held_data));
      chk($sformatf("bp_idh_%0d", i),   32'(a_rsp_id),     32'(0));
      chk($sformatf("bp_rdy1_%0d", i),  32'(a_req1_ready), 32'(0));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rdy1_same_cycle", 32'(a_req1_ready), 32'(0));
    step();
    chk("bp_released",   32'(a_rsp_valid),  32'(0));
    chk("bp_rdy1_after", 32'(a_req1_ready), 32'(1));
    step();
    req1_valid = 1'b0;
    chk("bp_req1_dp_a", 32'(a_dp_a), 32'h555);
    step();
    chk("bp_req1_data", 32'(a_rsp_data), 32'h055);
    chk("bp_req1_id",   32'(a_rsp_id),   32'(1));
    step();

    // Instance B: latency of 4 settle cycles
    rst_pulse();
    set_req(1'b0, 1'b1, 12'h3c3, 12'h0f0, 2'd2);
    #1;
    chk("b_ready0", 32'(b_req0_ready), 32'(1));
    step();
    req0_valid = 1'b0;
    chk("b_lat_0", 32'(b_rsp_valid), 32'(0));
    for (int j = 1; j <= int'(S_B); j++) begin
      step();
      chk($sformatf("b_lat_%0d", j), 32'(b_rsp_valid), 32'(j == int'(S_B)));
    end
    chk("b_lat_data", 32'(b_rsp_data), 32'h333);
    chk("b_lat_id",   32'(b_rsp_id),   32'(0));
    chk("b_lat_err",  32'(b_rsp_err),  32'(0));
    step();
    chk("b_lat_idle", 32'(b_busy), 32'(0));

    // Instance B: reset during WAIT drops the request
    set_req(1'b1, 1'b1, 12'h007, 12'h005, 2'd0);
    step();
    req1_valid = 1'b0;
    step();
    chk("b_wait_busy", 32'(b_busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("b_rst_busy",  32'(b_busy),      32'(0));
    chk("b_rst_dp_a",  32'(b_dp_a),      32'(0));
    chk("b_rst_dp_b",  32'(b_dp_b),      32'(0));
    chk("b_rst_valid", 32'(b_rsp_valid), 32'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_rsp_valid) seen++;
    end
    chk("b_dropped_no_rsp", 32'(seen), 32'(0));
    set_req(1'b0, 1'b1, 12'h001, 12'h001, 2'd0);
    set_req(1'b1, 1'b1, 12'h002, 12'h002, 2'd0);
    #1;
    chk("b_post_rst_gnt0", 32'(b_req0_ready), 32'(1));
    chk("b_post_rst_gnt1", 32'(b_req1_ready), 32'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Randomized traffic on A against a transaction-timeline model
    rst_pulse();
    m_busy = 1'b0; m_acc = 0; m_id = 1'b0; m_last = 1'b1;
    m_a = '0; m_b = '0; m_op = 2'd0;
    hs0 = 1'b0; hs1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      // Response is visible S cycles after the accept edge until consumed.
      exp_rv = m_busy && (n >= m_acc + int'(S_A));
      chk("rnd_rsp_valid", 32'(a_rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rnd_rsp_data", 32'(a_rsp_data), 32'(ref_res(m_a, m_b, m_op)));
        chk("rnd_rsp_id",   32'(a_rsp_id),   32'(m_id));
        chk("rnd_rsp_err",  32'(a_rsp_err),  32'(m_op == 2'd3));
      end
      chk("rnd_busy", 32'(a_busy), 32'(m_busy));
      chk("rnd_dp_a", 32'(a_dp_a), 32'(m_a));
      chk("rnd_dp_b", 32'(a_dp_b), 32'(m_b));

      // Requesters hold valid and operands until accepted.
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 2'($urandom);
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 2'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;

      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      chk("rnd_ready0", 32'(a_req0_ready), 32'(g0));
      chk("rnd_ready1", 32'(a_req1_ready), 32'(g1));

      hs0 = req0_valid && g0;
      hs1 = req1_valid && g1;
      if (hs0 || hs1) begin
        m_busy = 1'b1;
        m_acc  = n + 1;
        m_id   = hs1;
        m_last = hs1;
        m_a    = hs1 ? req1_a  : req0_a;
        m_b    = hs1 ? req1_b  : req0_b;
        m_op   = hs1 ? req1_op : req0_op;
      end else if (exp_rv && rsp_ready) begin
        m_busy = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
